// File: rtl/duty_ramp.sv
// duty_ramp: slew-limited signed duty command to PWM period/compare with reversal dead time.
// Optional command watchdog is built in when DUTY_RAMP_WDT_EN is defined.
module duty_ramp #(
    parameter int DEAD_PERIODS = 2,
    parameter int WDT_PERIODS  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_duty,
    output logic        cmd_ready,
    input  logic [31:0] cfg_period,
    input  logic [15:0] cfg_step,
    input  logic        pwm_fetch,
    output logic [31:0] pwm_period,
    output logic [31:0] pwm_compare,
    output logic        dir,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic {RUN, DEAD} state_t;

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_PERIODS - 1);

    state_t             state_q, state_d;
    logic signed [16:0] cur_q, cur_d;
    logic signed [16:0] tgt_q, tgt_d;
    logic signed [16:0] pend_q, pend_d;
    logic               dir_q, dir_d;
    logic [7:0]         dead_cnt_q, dead_cnt_d;
    logic               hold_q, hold_d;
    logic               ready_q;
    logic               busy_q, busy_d;
    logic [31:0]        period_q, period_d;
    logic               v1_q, v2_q, v2_d;
    logic [46:0]        prod_q, prod_d;
    logic [31:0]        cmp_q;

    logic               accept;
    logic               wdt_trip;
    logic signed [16:0] cmd_clamped;
    logic signed [16:0] tgt_new;
    logic signed [16:0] goal;
    logic signed [16:0] stepped;
    logic signed [16:0] step17;
    logic signed [17:0] diff, diff_abs, step18;
    logic               opp;
    logic [16:0]        cur_abs;

    assign accept = cmd_valid && ready_q;

    assign cmd_clamped = (cmd_duty == 16'h8000) ? -17'sd32767
                                                : $signed({cmd_duty[15], cmd_duty});

    assign tgt_new = wdt_trip ? '0 : pend_q;

    // Target on the far side of zero from dir: ramp only down to zero
    assign opp  = (tgt_new != '0) && (tgt_new[16] == dir_q);
    assign goal = opp ? '0 : tgt_new;

    assign step17   = $signed({1'b0, cfg_step});
    assign step18   = $signed({2'b00, cfg_step});
    assign diff     = $signed({goal[16], goal}) - $signed({cur_q[16], cur_q});
    assign diff_abs = diff[17] ? -diff : diff;

    always_comb begin
        stepped = goal;
        if (cfg_step != 16'd0 && diff_abs > step18) begin
            if (diff[17]) begin
                stepped = cur_q - step17;
            end else begin
                stepped = cur_q + step17;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        period_d   = period_q;
        busy_d     = busy_q;
        hold_d     = hold_q;

        if (accept) begin
            pend_d = cmd_clamped;
            hold_d = 1'b1;
        end else if (pwm_fetch) begin
            hold_d = 1'b0;
        end

        if (pwm_fetch) begin
            tgt_d    = tgt_new;
            period_d = cfg_period;
            if (wdt_trip) begin
                pend_d = '0;
            end
            unique case (state_q)
                RUN: begin
                    cur_d = stepped;
                    if (stepped == '0 && opp) begin
                        state_d    = DEAD;
                        dead_cnt_d = 8'd0;
                    end
                end
                DEAD: begin
                    cur_d      = '0;
                    dead_cnt_d = dead_cnt_q + 8'd1;
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = RUN;
                        dead_cnt_d = 8'd0;
                        if (opp) begin
                            dir_d = ~dir_q;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (pwm_fetch || accept) begin
            busy_d = (cur_d != tgt_d) || (state_d == DEAD);
        end
    end

    // Compare pipeline: a fetch while a result is in flight discards it
    assign cur_abs = cur_q[16] ? 17'(-cur_q) : 17'(cur_q);
    assign prod_d  = 47'(cur_abs) * 47'(period_q);
    assign v2_d    = v1_q && !pwm_fetch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cur_q      <= '0;
            tgt_q      <= '0;
            pend_q     <= '0;
            dir_q      <= 1'b1;
            dead_cnt_q <= 8'd0;
            hold_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            period_q   <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            prod_q     <= '0;
            cmp_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
            dead_cnt_q <= dead_cnt_d;
            hold_q     <= hold_d;
            ready_q    <= ~hold_d;
            busy_q     <= busy_d;
            period_q   <= period_d;
            v1_q       <= pwm_fetch;
            v2_q       <= v2_d;
            if (v1_q) begin
                prod_q <= prod_d;
            end
            if (v2_q) begin
                cmp_q <= 32'(prod_q >> 15);
            end
        end
    end

`ifdef DUTY_RAMP_WDT_EN
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        timeout_q;

    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (accept) begin
            wdt_cnt_d = 32'd0;
        end else if (pwm_fetch && wdt_cnt_q != 32'hFFFF_FFFF) begin
            wdt_cnt_d = wdt_cnt_q + 32'd1;
        end
    end

    assign wdt_trip = pwm_fetch && !accept && (wdt_cnt_d >= 32'(WDT_PERIODS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_cnt_q <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (wdt_trip) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wdt_trip = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign cmd_ready   = ready_q;
    assign pwm_period  = period_q;
    assign pwm_compare = cmp_q;
    assign dir         = dir_q;
    assign busy        = busy_q;

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter DEAD_PERIODS, default 2: PWM periods with zero duty held before a direction reversal (range 1..255).
REQ-002 Parameter WDT_PERIODS, default 1000: PWM periods without an accepted command before the watchdog trips (used only with DUTY_RAMP_WDT_EN).
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  signed duty command offered.
REQ-006 cmd_duty  input  16  signed duty, full scale +/-32767.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cfg_period  input  32  PWM period in clocks; sampled at each fetch.
REQ-009 cfg_step  input  16  unsigned max duty change per PWM period; 0 = no ramp.
REQ-010 pwm_fetch  input  1  downstream PWM period-start strobe, one clock wide.
REQ-011 pwm_period  output  32  period for the downstream PWM generator.
REQ-012 pwm_compare  output  32  compare value for the downstream PWM generator.
REQ-013 dir  output  1  1 = forward, 0 = reverse.
REQ-014 busy  output  1  current duty != target, or dead time in progress.
REQ-015 timeout  output  1  watchdog tripped; constant 0 without DUTY_RAMP_WDT_EN.

Function
REQ-016 Command accept: cmd_valid && cmd_ready; cmd_duty of -32768 shall be clamped to -32767 and stored as pending target.
REQ-017 cmd_ready shall drop the clock after an accept and rise the clock after the next pwm_fetch; at most one command per PWM period.
REQ-018 On pwm_fetch: pending target moves to target; pwm_period <= cfg_period; one ramp step executes.
REQ-019 Ramp step: if |target - cur| <= cfg_step or cfg_step == 0, then cur <= target; otherwise cur moves cfg_step toward target. Arithmetic is 17-bit signed with no wrap.
REQ-020 Zero crossing: cur shall stop at 0 when the target sign is opposite to dir.
REQ-021 States: RUN and DEAD.
REQ-022 RUN -> DEAD: on a fetch with cur == 0, target != 0, and sign(target) != dir.
REQ-023 DEAD behaviour: cur is held at 0 for DEAD_PERIODS fetches; then dir flips, RUN resumes, and ramping starts on the next fetch.
REQ-024 A target change while in DEAD (including back to dir's sign, or to 0) shall not abort the dead time; the dir flip is skipped if target is 0 or matches dir at exit.
REQ-025 dir shall change only on DEAD exit; cur == 0 with target == 0 leaves dir unchanged.
REQ-026 pwm_compare = (|cur| * pwm_period) >> 15, computed from the post-step cur and the new pwm_period, and registered exactly 2 clocks after pwm_fetch. Its value is always < pwm_period + 1.
REQ-027 A pwm_fetch arriving during the 2-clock compute shall restart the computation with the new values; no stale value shall be output after the newer one.
REQ-028 busy shall be a registered output that updates in the clock following each fetch or accept.

Reset
REQ-029 Reset asserted, at any time including mid-DEAD or mid-compute, shall set all of the following: pwm_period=0, pwm_compare=0, cur=0, target=0, pending=0, dir=1, busy=0, timeout=0, cmd_ready=0, state RUN, counters 0.
REQ-030 cmd_ready shall rise on the first clock edge after reset deasserts.

Configuration
REQ-031 Macro DUTY_RAMP_WDT_EN is optional; default is not defined.
REQ-032 With DUTY_RAMP_WDT_EN defined: a period counter increments on each fetch and clears on each accept. When it reaches WDT_PERIODS, target and pending shall be forced to 0 and timeout=1. timeout stays 1 until the next accept.
REQ-033 Without DUTY_RAMP_WDT_EN: no watchdog logic is present, and timeout is tied to 0.

Verification
REQ-034 Reset release; cfg_period=1000, cfg_step=0; accept +16384; fetch -> pwm_compare=500 two clocks later, dir=1, busy=0.
REQ-035 cfg_step=4096, cfg_period=32768; accept +16384 from 0 -> compare 4096, 8192, 12288, 16384 on successive fetches; busy falls after the 4th.
REQ-036 dir=1, cur=+8192, cfg_step=8192, DEAD_PERIODS=2; accept -8192 -> cur 0; 2 fetches at 0; dir=0; next fetch |cur|=8192.
REQ-037 Two back-to-back cmd_valid within one period -> second is held off (cmd_ready=0) until after the fetch; accept -32768 -> stored as -32767.
REQ-038 Reset pulse mid-DEAD -> all outputs match REQ-029 immediately; dir=1 after release.
REQ-039 With DUTY_RAMP_WDT_EN and WDT_PERIODS=3: accept +1000, then 3 fetches with no command -> timeout=1, target 0; a new accept clears timeout.
